// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stage requests and redirects in, per-stage stall/flush,
// redirect target, status and performance counters out.
interface pipe_ctrl_if #(
    parameter int STAGES = 6,
    parameter int AW     = 32,
    parameter int CNT_W  = 32
);
    logic [STAGES-1:0] stall_req;
    logic              excp_req;
    logic [AW-1:0]     excp_pc;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              redirect_valid;
    logic [AW-1:0]     redirect_pc;
    logic              busy;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output stall_req, excp_req, excp_pc,
        input  stall, flush, redirect_valid, redirect_pc, busy, stall_cycles, flush_count
    );

    modport slave (
        input  stall_req, excp_req, excp_pc,
        output stall, flush, redirect_valid, redirect_pc, busy, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: per-stage stall/bubble generation and precise redirect FSM.
// Optional stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int STAGES     = 6,
    parameter int EXCP_STAGE = 3,
    parameter int AW         = 32,
    parameter int CNT_W      = 32
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    // Stages at or before the redirecting stage, and the stages behind it that must drain first.
    localparam logic [STAGES-1:0] HOLD_MASK = STAGES'((1 << (EXCP_STAGE + 1)) - 1);
    localparam logic [STAGES-1:0] LATE_MASK = ~HOLD_MASK;

    state_t            state_p0;
    state_t            state_nxt;
    logic [STAGES-1:0] base_stall;
    logic [STAGES-1:0] stall_c;
    logic [STAGES-1:0] flush_c;
    logic              stall_acc;
    logic              late_req;
    logic [AW-1:0]     redirect_pc_p0;

    always_comb begin
        stall_acc  = 1'b0;
        base_stall = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            stall_acc     = stall_acc | bus.stall_req[i];
            base_stall[i] = stall_acc;
        end
    end

    assign late_req = |(bus.stall_req & LATE_MASK);

    always_comb begin
        state_nxt = state_p0;
        stall_c   = base_stall;
        case (state_p0)
            IDLE: begin
                if (bus.excp_req)
                    state_nxt = late_req ? PEND : FLUSH;
            end
            PEND: begin
                stall_c = base_stall | HOLD_MASK;
                if (!late_req)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                stall_c   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A bubble enters the first register downstream of a held one.
        flush_c = (stall_c << 1) & ~stall_c;
        if (state_p0 == FLUSH)
            flush_c = '1;
    end

    // Stage p0: FSM state and captured redirect target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0       <= IDLE;
            redirect_pc_p0 <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (state_p0 == IDLE && bus.excp_req)
                redirect_pc_p0 <= bus.excp_pc;
        end
    end

    assign bus.stall          = stall_c;
    assign bus.flush          = flush_c;
    assign bus.redirect_valid = (state_p0 == FLUSH);
    assign bus.redirect_pc    = redirect_pc_p0;
    assign bus.busy           = (state_p0 != IDLE);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_p0;
    logic [CNT_W-1:0] flush_count_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0: saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_p0 <= '0;
            flush_count_p0  <= '0;
        end else begin
            if (stall_c[0])
                stall_cycles_p0 <= sat_inc(stall_cycles_p0);
            if (state_p0 != FLUSH && state_nxt == FLUSH)
                flush_count_p0 <= sat_inc(flush_count_p0);
        end
    end

    assign bus.stall_cycles = stall_cycles_p0;
    assign bus.flush_count  = flush_count_p0;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-scenario tasks with a queue scoreboard of
// expected outputs, pushed when stimulus is driven and popped when outputs are sampled.
module tb_pipe_ctrl;
    localparam int STAGES = 6;
    localparam int AW     = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              busy;
        logic              rv;
        logic [AW-1:0]     pc;
        logic [STAGES-1:0] flush;
        logic [STAGES-1:0] stall;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGES(STAGES), .AW(AW), .CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.STAGES(STAGES), .EXCP_STAGE(3), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    obs_t exp_q[$];
    int   cnt_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic obs_t mk(input logic b, input logic rv, input logic [AW-1:0] pc,
                                input logic [STAGES-1:0] fl, input logic [STAGES-1:0] st);
        obs_t o;
        o.busy = b; o.rv = rv; o.pc = pc; o.flush = fl; o.stall = st;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(bus.busy, bus.redirect_valid, bus.redirect_pc, bus.flush, bus.stall);
    endfunction

    task automatic drive(input logic [STAGES-1:0] sr, input logic ex, input logic [AW-1:0] pc);
        @(negedge clk);
        bus.stall_req = sr;
        bus.excp_req  = ex;
        bus.excp_pc   = pc;
    endtask

    task automatic test_reset();
        obs_t act, expv;
        // Reset held low: state idle, outputs are the pure base function of stall_req.
        bus.stall_req = '0; bus.excp_req = 1'b0; bus.excp_pc = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        drive(6'b000000, 1'b0, '0);
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 6'b000000, 6'b000000));
        #1 act = observe(); expv = exp_q.pop_front(); n_checks++;
        if (act !== expv) begin n_fail++; $display("FAIL reset_idle: got %p want %p", act, expv); end
        n_checks++;
        if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_count);
        end
        drive(6'b000100, 1'b0, '0);
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 6'b001000, 6'b000111));
        #1 act = observe(); expv = exp_q.pop_front(); n_checks++;
        if (act !== expv) begin n_fail++; $display("FAIL reset_base_stall: got %p want %p", act, expv); end
        @(negedge clk);
        reset = 1'b1;
        bus.stall_req = '0;
    endtask

    task automatic test_base_stall();
        logic [STAGES-1:0] sr_t [6] = '{6'b000100, 6'b000000, 6'b100000, 6'b000001, 6'b010010, 6'b001000};
        logic [STAGES-1:0] st_t [6] = '{6'b000111, 6'b000000, 6'b111111, 6'b000001, 6'b011111, 6'b001111};
        logic [STAGES-1:0] fl_t [6] = '{6'b001000, 6'b000000, 6'b000000, 6'b000010, 6'b100000, 6'b010000};
        obs_t act, expv;
        for (int i = 0; i < 6; i++) begin
            drive(sr_t[i], 1'b0, '0);
            exp_q.push_back(mk(1'b0, 1'b0, 32'h0, fl_t[i], st_t[i]));
            #1 act = observe(); expv = exp_q.pop_front(); n_checks++;
            if (act !== expv) begin n_fail++; $display("FAIL base_stall[%0d]: got %p want %p", i, act, expv); end
        end
    endtask

    task automatic test_redirect();
        logic [STAGES-1:0] sr_t [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000000, 6'b000000};
        logic              ex_t [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [AW-1:0]     pi_t [6] = '{32'hBFC00380, 32'h0, 32'h0, 32'hA5A50000, 32'h0, 32'h0};
        logic              b_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic              rv_t [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [AW-1:0]     pc_t [6] = '{32'h0, 32'hBFC00380, 32'hBFC00380, 32'hBFC00380, 32'hA5A50000, 32'hA5A50000};
        logic [STAGES-1:0] fl_t [6] = '{6'b000000, 6'b111111, 6'b000000, 6'b010000, 6'b111111, 6'b000000};
        logic [STAGES-1:0] st_t [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b001111, 6'b000000, 6'b000000};
        obs_t act, expv;
        for (int i = 0; i < 6; i++) begin
            drive(sr_t[i], ex_t[i], pi_t[i]);
            exp_q.push_back(mk(b_t[i], rv_t[i], pc_t[i], fl_t[i], st_t[i]));
            #1 act = observe(); expv = exp_q.pop_front(); n_checks++;
            if (act !== expv) begin n_fail++; $display("FAIL redirect[%0d]: got %p want %p", i, act, expv); end
        end
    endtask

    task automatic test_pend();
        // Blocking stall at stage 4 holds the redirect; a second request in PEND is dropped.
        logic [STAGES-1:0] sr_t [6] = '{6'b010000, 6'b010000, 6'b010000, 6'b000000, 6'b000100, 6'b000000};
        logic              ex_t [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0]     pi_t [6] = '{32'h12345678, 32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0};
        logic              b_t  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic              rv_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [AW-1:0]     pc_t [6] = '{32'hA5A50000, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        logic [STAGES-1:0] fl_t [6] = '{6'b100000, 6'b100000, 6'b100000, 6'b010000, 6'b111111, 6'b000000};
        logic [STAGES-1:0] st_t [6] = '{6'b011111, 6'b011111, 6'b011111, 6'b001111, 6'b000000, 6'b000000};
        obs_t act, expv;
        for (int i = 0; i < 6; i++) begin
            drive(sr_t[i], ex_t[i], pi_t[i]);
            exp_q.push_back(mk(b_t[i], rv_t[i], pc_t[i], fl_t[i], st_t[i]));
            #1 act = observe(); expv = exp_q.pop_front(); n_checks++;
            if (act !== expv) begin n_fail++; $display("FAIL pend[%0d]: got %p want %p", i, act, expv); end
        end
    endtask

    task automatic test_reset_pend();
        logic              rs_t [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [STAGES-1:0] sr_t [6] = '{6'b100000, 6'b100000, 6'b100000, 6'b000000, 6'b000000, 6'b000000};
        logic              ex_t [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic              b_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0]     pc_t [6] = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [STAGES-1:0] st_t [6] = '{6'b111111, 6'b111111, 6'b111111, 6'b000000, 6'b000000, 6'b000000};
        obs_t act, expv;
        for (int i = 0; i < 6; i++) begin
            drive(sr_t[i], ex_t[i], 32'hDEADBEEF);
            reset = rs_t[i];
            exp_q.push_back(mk(b_t[i], 1'b0, pc_t[i], 6'b000000, st_t[i]));
            #1 act = observe(); expv = exp_q.pop_front(); n_checks++;
            if (act !== expv) begin n_fail++; $display("FAIL reset_pend[%0d]: got %p want %p", i, act, expv); end
            if (i >= 2) begin
                n_checks++;
                if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
                    n_fail++; $display("FAIL reset_pend_cnt[%0d]: got %0d/%0d want 0/0", i, bus.stall_cycles, bus.flush_count);
                end
            end
        end
    endtask

    task automatic test_perf();
        int e_sc, e_fc, got;
        for (int i = 0; i <= 20; i++) begin
            drive((i < 20) ? 6'b000001 : 6'b000000, 1'b0, '0);
`ifdef PIPE_CTRL_PERF_EN
            cnt_q.push_back((i > 15) ? 15 : i);
`else
            cnt_q.push_back(0);
`endif
            #1 got = int'(bus.stall_cycles); e_sc = cnt_q.pop_front(); n_checks++;
            if (got !== e_sc) begin n_fail++; $display("FAIL stall_cycles[%0d]: got %0d want %0d", i, got, e_sc); end
        end
        for (int r = 0; r < 2; r++) begin
            drive(6'b000000, 1'b1, 32'h00400000 + AW'(r));
            drive(6'b000000, 1'b0, '0);
            drive(6'b000000, 1'b0, '0);
`ifdef PIPE_CTRL_PERF_EN
            cnt_q.push_back(r + 1);
`else
            cnt_q.push_back(0);
`endif
            #1 got = int'(bus.flush_count); e_fc = cnt_q.pop_front(); n_checks++;
            if (got !== e_fc) begin n_fail++; $display("FAIL flush_count[%0d]: got %0d want %0d", r, got, e_fc); end
        end
`ifdef PIPE_CTRL_PERF_EN
        e_sc = 15;
`else
        e_sc = 0;
`endif
        got = int'(bus.stall_cycles); n_checks++;
        if (got !== e_sc) begin n_fail++; $display("FAIL stall_cycles_hold: got %0d want %0d", got, e_sc); end
    endtask

    initial begin
        test_reset();
        test_base_stall();
        test_redirect();
        test_pend();
        test_reset_pend();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the five-stage MIPS core. It replaces the fixed externally driven 6-bit `stall` vector with per-stage stall generation from stage requests, plus automatic bubble insertion. It also adds precise redirect handling: an FSM holds a redirect until later stages drain, then flushes the whole pipe and issues the new PC. It sits beside the pipeline registers (pc, if_id, id_exe, exe_mem, mem_wb) and drives their `stall`/flush inputs.

## Interface
- `STAGES`, 6, number of controlled stages; index 0 = PC register, index STAGES-1 = last pipeline register.
- `EXCP_STAGE`, 3, index of the stage that raises redirects (EXE/MEM boundary); must be < STAGES.
- `AW`, 32, redirect PC width.
- `CNT_W`, 32, performance counter width.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall_req`  in  STAGES  bit j = stage j cannot advance this cycle.
- `excp_req`  in  1  redirect/exception request from stage EXCP_STAGE, single-cycle pulse.
- `excp_pc`  in  AW  target PC, valid with `excp_req`.
- `stall`  out  STAGES  bit i = hold register i.
- `flush`  out  STAGES  bit i = load bubble (NOP, all control bits 0) into register i.
- `redirect_valid`  out  1  PC register must load `redirect_pc` this cycle.
- `redirect_pc`  out  AW  captured redirect target.
- `busy`  out  1  FSM not in IDLE.
- `stall_cycles`  out  CNT_W  cycles with `stall[0]`=1 (see Configuration).
- `flush_count`  out  CNT_W  number of FLUSH entries (see Configuration).

## Operation
- FSM states: IDLE, PEND, FLUSH.
- Base stall: `stall[i]` = OR of `stall_req[STAGES-1:i]`. A request from stage j holds stages 0..j.
- Bubble: `flush[i]` = `stall[i-1]` & ~`stall[i]` for i ≥ 1. `flush[0]` = 0 outside FLUSH.
- IDLE, `excp_req`=1:
  - capture `excp_pc` into `redirect_pc`.
  - If any `stall_req[j]` with j > EXCP_STAGE, go to PEND; else go to FLUSH.
- PEND:
  - `stall[i]` forced to 1 for i ≤ EXCP_STAGE, ORed with the base stall.
  - Exit to FLUSH in the first cycle where `stall_req[STAGES-1:EXCP_STAGE+1]` = 0.
- FLUSH (exactly 1 cycle):
  - `stall` = 0, `flush` = all ones, `redirect_valid` = 1.
  - Return to IDLE.
- Events ignored:
  - `excp_req` in PEND or FLUSH (the first redirect wins; issuing a second one while `busy`=1 is a software-visible error).
  - `stall_req` in FLUSH.
- Same cycle `excp_req` and `stall_req` in IDLE: the base stall applies for that cycle. The exception is still captured, and the transition follows the PEND/FLUSH rule above.
- `busy` = (state ≠ IDLE).

## Timing
- `stall`, and `flush` outside FLUSH: combinational from `stall_req` and state, zero latency.
- Redirect latency:
  - `excp_req` at cycle t with no blocking stall → FLUSH and `redirect_valid` at t+1 → IDLE at t+2.
  - With blocking stall → FLUSH 1 cycle after the blocking requests drop.
- `redirect_valid` and the FLUSH-state `flush` are decoded directly from the state register, with no extra pipeline delay.
- Reset (asynchronous assert, synchronous deassert by system):
  - state = IDLE, `redirect_pc` = 0, `redirect_valid` = 0, counters = 0.
  - `stall`/`flush` are then purely the base function of `stall_req`.
- Reset asserted in PEND/FLUSH: the pending redirect is discarded; no `redirect_valid` after release.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments each cycle `stall[0]`=1.
  - `flush_count` increments on each IDLE/PEND→FLUSH transition.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Not defined: both outputs tied to 0, and the counter registers are not synthesised. The port list is unchanged.

## Test plan
- `stall_req`=6'b000100, STAGES=6 → `stall`=6'b000111, `flush`=6'b001000, `busy`=0.
- `excp_req` with `excp_pc`=0xBFC00380, no stalls:
  - next cycle: `flush`=6'b111111, `stall`=0, `redirect_valid`=1, `redirect_pc`=0xBFC00380.
  - following cycle: IDLE.
- `stall_req[4]`=1 held 3 cycles with `excp_req` in cycle 0:
  - PEND for 3 cycles, `stall`=6'b011111.
  - FLUSH in cycle 4 (the cycle after `stall_req[4]` drops).
- Second `excp_req` (pc 0x80000000) during PEND → ignored; FLUSH issues the first captured PC.
- Reset pulled low during PEND → `busy`=0 immediately, no `redirect_valid` after release, counters = 0.
- With `PIPE_CTRL_PERF_EN`, CNT_W=4:
  - 20 stall cycles → `stall_cycles`=15 (saturated).
  - 2 redirects → `flush_count`=2.
  - Without the macro, both read 0.
